// File: rtl/cache_arbiter_if.sv
// Bundles the instruction-cache, data-cache and shared memory-port signals seen by cache_arbiter.
// master is the arbiter's view; slave is the caches' and memory's view.
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    logic                  icache_read;
    logic [ADDR_WIDTH-1:0] icache_address;
    logic [LINE_WIDTH-1:0] icache_rdata;
    logic                  icache_resp;

    logic                  dcache_read;
    logic                  dcache_write;
    logic [ADDR_WIDTH-1:0] dcache_address;
    logic [LINE_WIDTH-1:0] dcache_wdata;
    logic [LINE_WIDTH-1:0] dcache_rdata;
    logic                  dcache_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        input  icache_read, icache_address,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output icache_read, icache_address,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction cache and a data cache.
// One transaction at a time: grant, serve until pmem_resp, one DONE turnaround cycle, back to IDLE.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_arbiter_if.master       bus,
    output logic                  busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    logic                  last_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  rd_q;
    logic                  wr_q;
    logic                  busy_q;

    logic d_req;
    logic grant_i;
    logic grant_d;

    // last_d records the winner of the most recent contended grant only;
    // uncontended grants leave it alone, so contests alternate D, I, D, ...
    assign d_req   = bus.dcache_read | bus.dcache_write;
    assign grant_i = bus.icache_read & (~d_req | last_d);
    assign grant_d = d_req & (~bus.icache_read | ~last_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state  <= SERVE_I;
                        addr_q <= bus.icache_address;
                        rd_q   <= 1'b1;
                        wr_q   <= 1'b0;
                        busy_q <= 1'b1;
                        if (d_req) last_d <= 1'b0;
                    end else if (grant_d) begin
                        // A simultaneous read and write resolves to the write-back.
                        state  <= SERVE_D;
                        addr_q <= bus.dcache_address;
                        rd_q   <= ~bus.dcache_write;
                        wr_q   <= bus.dcache_write;
                        busy_q <= 1'b1;
                        if (bus.dcache_write) wdata_q <= bus.dcache_wdata;
                        if (bus.icache_read)  last_d  <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        state <= DONE;
                        rd_q  <= 1'b0;
                        wr_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    rd_q   <= 1'b0;
                    wr_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Control outputs are forced low while reset is held, even before the reset edge.
    assign bus.pmem_read    = rd_q & rst_n;
    assign bus.pmem_write   = wr_q & rst_n;
    assign busy             = busy_q & rst_n;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    assign bus.icache_resp  = rst_n & bus.pmem_resp & (state == SERVE_I);
    assign bus.dcache_resp  = rst_n & bus.pmem_resp & (state == SERVE_D);
    assign bus.icache_rdata = bus.pmem_rdata;
    assign bus.dcache_rdata = bus.pmem_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the memory port (0 none, 1 I, 2 D),
    // whether a turnaround cycle is pending, and who won the last contest.
    int          m_owner = 0;
    bit          m_turn  = 1'b0;
    bit          m_d_won = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    bit          m_wr    = 1'b0;
    logic [LW-1:0] m_wdata = '0;
    bit          got_i = 1'b0;
    bit          got_d = 1'b0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic compare();
        bit e_busy, e_rd, e_wr, e_ir, e_dr;
        e_busy = rst_n && (m_owner != 0 || m_turn);
        e_rd   = rst_n && (m_owner == 1 || (m_owner == 2 && !m_wr));
        e_wr   = rst_n && m_owner == 2 && m_wr;
        e_ir   = rst_n && bus.pmem_resp && m_owner == 1;
        e_dr   = rst_n && bus.pmem_resp && m_owner == 2;
        check("busy", LW'(busy), LW'(e_busy));
        check("pmem_read", LW'(bus.pmem_read), LW'(e_rd));
        check("pmem_write", LW'(bus.pmem_write), LW'(e_wr));
        check("icache_resp", LW'(bus.icache_resp), LW'(e_ir));
        check("dcache_resp", LW'(bus.dcache_resp), LW'(e_dr));
        check("icache_rdata", bus.icache_rdata, bus.pmem_rdata);
        check("dcache_rdata", bus.dcache_rdata, bus.pmem_rdata);
        if (e_rd || e_wr) check("pmem_address", LW'(bus.pmem_address), LW'(m_addr));
        if (e_wr) check("pmem_wdata", bus.pmem_wdata, m_wdata);
        got_i = e_ir;
        got_d = e_dr;
    endtask

    task automatic model_update();
        bit ir, dr;
        int win;
        if (!rst_n) begin
            m_owner = 0; m_turn = 1'b0; m_d_won = 1'b0;
            m_addr = '0; m_wr = 1'b0; m_wdata = '0;
        end else if (m_turn) begin
            m_turn = 1'b0;
        end else if (m_owner != 0) begin
            if (bus.pmem_resp) begin
                m_owner = 0;
                m_turn  = 1'b1;
            end
        end else begin
            ir = bus.icache_read;
            dr = bus.dcache_read || bus.dcache_write;
            if (ir && dr) begin
                win     = m_d_won ? 1 : 2;
                m_d_won = (win == 2);
            end else begin
                win = ir ? 1 : (dr ? 2 : 0);
            end
            if (win == 1) begin
                m_owner = 1; m_addr = bus.icache_address; m_wr = 1'b0;
            end else if (win == 2) begin
                m_owner = 2; m_addr = bus.dcache_address; m_wr = bus.dcache_write;
                if (bus.dcache_write) m_wdata = bus.dcache_wdata;
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model on the edge,
    // and hand control back just after the edge for the next stimulus.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.icache_read = 1'b0; bus.dcache_read = 1'b0; bus.dcache_write = 1'b0;
        bus.pmem_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [LW-1:0] pat_a;
    logic [LW-1:0] pat_b;

    initial begin
        clear_inputs();
        bus.icache_address = '0; bus.dcache_address = '0;
        bus.dcache_wdata = '0; bus.pmem_rdata = '0;
        pat_a = rand_line();
        pat_b = rand_line();
        @(posedge clk);
        model_update();
        #1;
        step();
        rst_n = 1'b1;
        check("rst_busy", LW'(busy), '0);
        check("rst_pmem_read", LW'(bus.pmem_read), '0);
        step();
        check("idle_pmem_write", LW'(bus.pmem_write), '0);

        // Uncontended instruction fill.
        bus.icache_read = 1'b1; bus.icache_address = 32'h0000_1000;
        step();
        check("ifill_read", LW'(bus.pmem_read), LW'(1'b1));
        check("ifill_addr", LW'(bus.pmem_address), LW'(32'h0000_1000));
        bus.pmem_resp = 1'b1; bus.pmem_rdata = pat_a;
        #1;
        check("ifill_resp", LW'(bus.icache_resp), LW'(1'b1));
        check("ifill_rdata", bus.icache_rdata, pat_a);
        step();
        clear_inputs();
        #1;
        check("ifill_done_busy", LW'(busy), LW'(1'b1));
        check("ifill_done_resp", LW'(bus.icache_resp), '0);
        step();
        check("ifill_idle_busy", LW'(busy), '0);

        // Contention after reset: D first, then I, then next contest goes to I.
        do_reset();
        bus.icache_read = 1'b1; bus.icache_address = 32'h0000_3000;
        bus.dcache_read = 1'b1; bus.dcache_address = 32'h0000_2000;
        step();
        check("rr1_addr_d", LW'(bus.pmem_address), LW'(32'h0000_2000));
        bus.pmem_resp = 1'b1;
        step();
        bus.dcache_read = 1'b0; bus.pmem_resp = 1'b0;
        step();
        step();
        check("rr1_addr_i", LW'(bus.pmem_address), LW'(32'h0000_3000));
        bus.pmem_resp = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        bus.icache_read = 1'b1; bus.dcache_read = 1'b1;
        step();
        check("rr2_addr_i", LW'(bus.pmem_address), LW'(32'h0000_3000));
        bus.pmem_resp = 1'b1;
        #1;
        check("rr2_iresp", LW'(bus.icache_resp), LW'(1'b1));
        step();
        clear_inputs();
        step();
        step();

        // Data write-back, then read+write collision.
        bus.dcache_write = 1'b1; bus.dcache_address = 32'h8000_0040; bus.dcache_wdata = pat_b;
        step();
        check("wb_write", LW'(bus.pmem_write), LW'(1'b1));
        check("wb_read", LW'(bus.pmem_read), '0);
        check("wb_wdata", bus.pmem_wdata, pat_b);
        bus.pmem_resp = 1'b1;
        #1;
        check("wb_dresp", LW'(bus.dcache_resp), LW'(1'b1));
        check("wb_iresp", LW'(bus.icache_resp), '0);
        step();
        clear_inputs();
        step();
        bus.dcache_read = 1'b1; bus.dcache_write = 1'b1;
        step();
        check("rw_write", LW'(bus.pmem_write), LW'(1'b1));
        check("rw_read", LW'(bus.pmem_read), '0);
        bus.pmem_resp = 1'b1;
        step();
        clear_inputs();
        step();

        // Spurious pmem_resp while idle.
        step();
        bus.pmem_resp = 1'b1;
        #1;
        check("spur_iresp", LW'(bus.icache_resp), '0);
        check("spur_dresp", LW'(bus.dcache_resp), '0);
        step();
        bus.pmem_resp = 1'b0;
        check("spur_busy", LW'(busy), '0);

        // Reset during an instruction fill, then a late pmem_resp.
        bus.icache_read = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; bus.icache_read = 1'b0; bus.pmem_resp = 1'b1;
        #1;
        check("abort_iresp", LW'(bus.icache_resp), '0);
        check("abort_busy", LW'(busy), '0);
        step();
        check("abort_idle", LW'(busy), '0);
        clear_inputs();
        step();

        // Random traffic: requesters hold until resp, rare drops and resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (bus.icache_read) begin
                if (got_i || $urandom_range(0, 63) == 0) bus.icache_read = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.icache_read = 1'b1; bus.icache_address = $urandom;
            end
            if (bus.dcache_read || bus.dcache_write) begin
                if (got_d || $urandom_range(0, 63) == 0) begin
                    bus.dcache_read = 1'b0; bus.dcache_write = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin bus.dcache_read = 1'b1; bus.dcache_write = 1'b0; end
                    1:       begin bus.dcache_read = 1'b0; bus.dcache_write = 1'b1; end
                    default: begin bus.dcache_read = 1'b1; bus.dcache_write = 1'b1; end
                endcase
                bus.dcache_address = $urandom;
                bus.dcache_wdata   = rand_line();
            end
            bus.pmem_resp  = ($urandom_range(0, 2) == 0);
            bus.pmem_rdata = rand_line();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: LINE_WIDTH, default 256, cache-line width in bits on all data buses.
REQ-002 Parameter: ADDR_WIDTH, default 32, byte address width on all address buses.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: icache_read  input  1  instruction-cache line-fill request.
REQ-006 Port: icache_address  input  ADDR_WIDTH  instruction-cache line address.
REQ-007 Port: icache_rdata  output  LINE_WIDTH  fill data to the instruction cache.
REQ-008 Port: icache_resp  output  1  instruction-cache transaction complete.
REQ-009 Port: dcache_read / dcache_write  input  1 each  data-cache fill / write-back request.
REQ-010 Port: dcache_address  input  ADDR_WIDTH  data-cache line address.
REQ-011 Port: dcache_wdata  input  LINE_WIDTH  data-cache write-back line.
REQ-012 Port: dcache_rdata  output  LINE_WIDTH  fill data to the data cache.
REQ-013 Port: dcache_resp  output  1  data-cache transaction complete.
REQ-014 Port: pmem_read / pmem_write  output  1 each  shared memory-port commands.
REQ-015 Port: pmem_address  output  ADDR_WIDTH  shared memory-port address.
REQ-016 Port: pmem_wdata  output  LINE_WIDTH  shared memory-port write line.
REQ-017 Port: pmem_rdata  input  LINE_WIDTH  memory read line.
REQ-018 Port: pmem_resp  input  1  memory transaction complete, one-cycle pulse.
REQ-019 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, SERVE_I, SERVE_D, DONE; held in a state register.
REQ-021 IDLE: only icache_read -> SERVE_I; only dcache_read|dcache_write -> SERVE_D; both -> grant goes to the requester not granted last (round-robin); none -> stay in IDLE.
REQ-022 The last-grant bit resets to "I granted", so the first contended grant goes to D.
REQ-023 On the grant edge, the arbiter latches the winner's address, the op (read/write) and, for a D write, wdata; pmem_* outputs are driven only from these latched values.
REQ-024 SERVE_I: pmem_read=1 and pmem_write=0 until pmem_resp.
REQ-025 SERVE_D: exactly one of pmem_read/pmem_write=1 per the latched op; if dcache_read and dcache_write are both high at grant, the write wins.
REQ-026 In a SERVE state with pmem_resp=1: the granted requester's resp=1 in that same cycle, and the FSM moves to DONE on the next edge.
REQ-027 DONE lasts one cycle with all pmem commands and both resp outputs low, then the FSM returns to IDLE; this gives a 1-cycle turnaround so requesters can drop their request.
REQ-028 icache_rdata and dcache_rdata both equal pmem_rdata combinationally; only the resp strobes qualify the data.
REQ-029 pmem_resp in IDLE or DONE is ignored and asserts no resp.
REQ-030 Requesters hold their request until resp; if a request drops mid-service, the arbiter still completes the latched transaction and pulses resp.
REQ-031 Latency from request (uncontended, in IDLE) to the first pmem command is 1 cycle; from pmem_resp to the next possible grant is 2 cycles.
REQ-032 A requester that loses arbitration is served next, with no starvation: worst-case wait is one other transaction.

Reset
REQ-033 With rst_n=0 at an edge: state=IDLE, last-grant=I, latched address/op/wdata cleared to 0.
REQ-034 During reset and in the following IDLE cycle: pmem_read, pmem_write, icache_resp, dcache_resp and busy are all 0.
REQ-035 Reset asserted mid-transaction aborts the transaction: no resp is issued, and a late pmem_resp is ignored per REQ-029.

Verification
REQ-036 Uncontended I fill: icache_read=1, addr=0x0000_1000 -> next cycle pmem_read=1 with addr 0x1000; pmem_resp pulsed with rdata=pattern A -> icache_resp=1 and icache_rdata=A in that cycle; then DONE, then IDLE.
REQ-037 Simultaneous requests right after reset: icache_read and dcache_read -> D served first; I is granted in the cycle after DONE; a second simultaneous pair -> I first.
REQ-038 D write-back: dcache_write=1, addr=0x8000_0040, wdata=B -> pmem_write=1, pmem_wdata=B, pmem_read=0; resp is pulsed to D only.
REQ-039 D read and write both high -> pmem_write=1 only.
REQ-040 Spurious pmem_resp in IDLE -> both resp stay 0 and the state stays IDLE.
REQ-041 rst_n=0 during SERVE_I, then pmem_resp after reset is released -> no icache_resp, state IDLE, busy=0.
